// File: rtl/axis_frame_gen_pkg.sv
// Shared types and helpers for the AXIS frame generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Width of the saturating frame counters.
    localparam int FRAMES_W = 32;

    // Widest lane count the keep helper can describe (1024-bit TDATA).
    localparam int KEEP_MAX = 128;

    // Last-beat keep mask. A zero remainder means the final beat is full.
    function automatic logic [KEEP_MAX-1:0] last_keep(input int rem, input int lanes);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            m[i] = (rem == 0) ? (i < lanes) : (i < rem);
        end
        return m;
    endfunction

endpackage

// File: rtl/AXIS_IF.sv
// AXI-Stream bundle with master/slave views; widths are interface parameters.
// Latency: none (wires only).
// Backpressure: tready from slave to master, standard valid/ready.
interface AXIS_IF #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 1
) ();
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic [TKEEP_WIDTH-1:0] tstrb;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   twakeup;

    modport Master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
        input  tready
    );

    modport Slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
        output tready
    );
endinterface

// File: rtl/axis_frame_gen_pattern.sv
// Lane generator: maps (base byte, bytes remaining) to tdata/tkeep/tlast for one beat.
// Latency: purely combinational; the caller holds the inputs in registers.
// Backpressure: none here; outputs stay stable as long as the registered inputs do.
module axis_frame_gen_pattern
    import axis_frame_gen_pkg::*;
#(
    parameter int DW   = 32,
    parameter int LENW = 16
) (
    input  logic            active,
    input  logic [7:0]      base_byte,
    input  logic [LENW-1:0] rem_bytes,
    output logic [DW-1:0]   tdata,
    output logic [DW/8-1:0] tkeep,
    output logic            tlast
);
    localparam int BYTES = DW / 8;

    logic last_beat;

    assign last_beat = (32'(rem_bytes) <= 32'(BYTES));

    // Lane k carries base+k while bytes remain; lanes past the frame end drive 0.
    always_comb begin
        tdata = '0;
        tkeep = '0;
        tlast = 1'b0;
        if (active) begin
            tlast = last_beat;
            tkeep = last_beat ? BYTES'(last_keep(int'(32'(rem_bytes) % 32'(BYTES)), BYTES))
                              : '1;
            for (int k = 0; k < BYTES; k++) begin
                if (32'(rem_bytes) > 32'(k)) begin
                    tdata[8*k +: 8] = base_byte + 8'(k);
                end
            end
        end
    end

endmodule

// File: rtl/axis_frame_gen.sv
// AXIS test-frame source: incrementing byte frames, per-run count/length/gap (ERR_INJECT: AXIS_FRAME_GEN_ERR_INJECT_EN).
// Latency: first tvalid one cycle after an accepted start; done pulses the cycle after the final tlast handshake.
// Backpressure: beats advance only on tvalid&&tready; all stream outputs hold while stalled.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int MAX_LEN     = 65535,
    parameter int DEFAULT_IFG = 0,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    AXIS_IF.Master                       out_axis_if,
    input  logic                         start,
    input  logic                         stop,
    input  logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    input  logic [15:0]                  frame_count,
    input  logic [7:0]                   ifg,
    input  logic                         ifg_override,
    input  logic [7:0]                   seed,
    input  logic [TID_WIDTH-1:0]         tid_in,
    input  logic [TDEST_WIDTH-1:0]       tdest_in,
    output logic                         busy,
    output logic                         done,
    output logic                         config_err,
    output logic [FRAMES_W-1:0]          frames_sent
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
    ,
    input  logic [7:0]                   err_every,
    output logic [FRAMES_W-1:0]          frames_bad
`endif
);
    localparam int DW    = $bits(out_axis_if.tdata);
    localparam int BYTES = DW / 8;
    localparam int UW    = $bits(out_axis_if.tuser);
    localparam int LENW  = $clog2(MAX_LEN + 1);

    if ((DW % 8) != 0) begin : g_bad_tdata
        $error("axis_frame_gen: TDATA_WIDTH must be a multiple of 8");
    end
    if ($bits(out_axis_if.tid) != TID_WIDTH || $bits(out_axis_if.tdest) != TDEST_WIDTH) begin : g_bad_route
        $error("axis_frame_gen: TID/TDEST widths disagree with the interface");
    end

    // Run configuration captured on an accepted start.
    typedef struct packed {
        logic [LENW-1:0]        len;
        logic [15:0]            count;
        logic [7:0]             ifg;
        logic [7:0]             seed;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
    } cfg_t;

    state_t            state_q, state_d;
    cfg_t              cfg_q;
    logic [LENW-1:0]   rem_q;
    logic [7:0]        base_q;
    logic [15:0]       run_cnt_q;
    logic [7:0]        gap_q;
    logic              stop_seen_q;
    logic              done_q;
    logic              cerr_q;
    logic [FRAMES_W-1:0] sent_q;

    logic              tvalid_int;
    logic              busy_int;
    logic [DW-1:0]     pat_tdata;
    logic [BYTES-1:0]  pat_tkeep;
    logic              pat_tlast;
    logic              beat_hs;
    logic              last_hs;
    logic              start_ok;
    logic              start_bad;
    logic              stop_now;
    logic              count_hit;
    logic              finishing;
    logic [7:0]        ifg_eff;
    logic [UW-1:0]     tuser_int;

    assign ifg_eff   = ifg_override ? ifg : 8'(DEFAULT_IFG);
    assign start_ok  = (state_q == IDLE) && start && (frame_len != '0);
    assign start_bad = (state_q == IDLE) && start && (frame_len == '0);
    assign beat_hs   = tvalid_int && out_axis_if.tready;
    assign last_hs   = beat_hs && pat_tlast;
    // A stop on the same cycle as the closing handshake still ends the run there.
    assign stop_now  = stop_seen_q || stop;
    // Equality against the latched count lets a 16-bit counter cover 65535 frames; 0 never matches.
    assign count_hit = (cfg_q.count != 16'd0) && ((run_cnt_q + 16'd1) == cfg_q.count);
    assign finishing = ((state_q == SEND) && last_hs && (count_hit || stop_now)) ||
                       ((state_q == GAP) && stop_now);

    axis_frame_gen_pattern #(
        .DW   (DW),
        .LENW (LENW)
    ) u_pattern (
        .active    (tvalid_int),
        .base_byte (base_q),
        .rem_bytes (rem_q),
        .tdata     (pat_tdata),
        .tkeep     (pat_tkeep),
        .tlast     (pat_tlast)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: frames never end early; stop is only acted on at frame boundaries or in the gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_hs) begin
                    if (count_hit || stop_now) begin
                        state_d = IDLE;
                    end else if (cfg_q.ifg != 8'd0) begin
                        state_d = GAP;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                if (stop_now) begin
                    state_d = IDLE;
                end else if (gap_q <= 8'd1) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: valid only while sending, busy for any non-idle state.
    always_comb begin
        tvalid_int = 1'b0;
        busy_int   = 1'b0;
        case (state_q)
            SEND: begin
                tvalid_int = 1'b1;
                busy_int   = 1'b1;
            end
            GAP: begin
                busy_int = 1'b1;
            end
            default: begin
                tvalid_int = 1'b0;
                busy_int   = 1'b0;
            end
        endcase
    end

    // Config latch, beat/gap/frame counters, status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q       <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            run_cnt_q   <= '0;
            gap_q       <= '0;
            stop_seen_q <= 1'b0;
            done_q      <= 1'b0;
            cerr_q      <= 1'b0;
            sent_q      <= '0;
        end else begin
            done_q <= finishing;
            cerr_q <= start_bad;
            if (start_ok) begin
                cfg_q       <= '{len: frame_len, count: frame_count, ifg: ifg_eff,
                                 seed: seed, tid: tid_in, tdest: tdest_in};
                rem_q       <= frame_len;
                base_q      <= seed;
                run_cnt_q   <= '0;
                stop_seen_q <= 1'b0;
                sent_q      <= '0;
            end else begin
                if ((state_q != IDLE) && stop) begin
                    stop_seen_q <= 1'b1;
                end
                if (beat_hs) begin
                    if (pat_tlast) begin
                        // Rewind the pattern so the next frame restarts at the seed.
                        rem_q     <= cfg_q.len;
                        base_q    <= cfg_q.seed;
                        run_cnt_q <= run_cnt_q + 16'd1;
                        gap_q     <= cfg_q.ifg;
                        if (sent_q != {FRAMES_W{1'b1}}) begin
                            sent_q <= sent_q + 1'b1;
                        end
                    end else begin
                        rem_q  <= rem_q - LENW'(BYTES);
                        base_q <= base_q + 8'(BYTES);
                    end
                end
                if ((state_q == GAP) && (gap_q != 8'd0)) begin
                    gap_q <= gap_q - 8'd1;
                end
            end
        end
    end

`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
    if (UW < 1) begin : g_bad_tuser
        $error("axis_frame_gen: error injection needs TUSER_WIDTH >= 1");
    end

    logic [7:0]          err_every_q;
    logic [7:0]          err_cnt_q;
    logic [FRAMES_W-1:0] bad_q;
    logic                err_mark;

    assign err_mark  = (err_every_q != 8'd0) && ((err_cnt_q + 8'd1) == err_every_q);
    assign tuser_int = UW'(tvalid_int && pat_tlast && err_mark);
    assign frames_bad = bad_q;

    // Every err_every-th frame of a run is flagged on its last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_every_q <= '0;
            err_cnt_q   <= '0;
            bad_q       <= '0;
        end else if (start_ok) begin
            err_every_q <= err_every;
            err_cnt_q   <= '0;
            bad_q       <= '0;
        end else if (last_hs) begin
            err_cnt_q <= err_mark ? 8'd0 : err_cnt_q + 8'd1;
            if (err_mark && (bad_q != {FRAMES_W{1'b1}})) begin
                bad_q <= bad_q + 1'b1;
            end
        end
    end
`else
    assign tuser_int = '0;
`endif

    assign out_axis_if.tvalid  = tvalid_int;
    assign out_axis_if.tdata   = pat_tdata;
    assign out_axis_if.tkeep   = pat_tkeep;
    assign out_axis_if.tstrb   = pat_tkeep;
    assign out_axis_if.tlast   = pat_tlast;
    assign out_axis_if.tid     = cfg_q.tid;
    assign out_axis_if.tdest   = cfg_q.tdest;
    assign out_axis_if.tuser   = tuser_int;
    assign out_axis_if.twakeup = 1'b0;

    assign busy        = busy_int;
    assign done        = done_q;
    assign config_err  = cerr_q;
    assign frames_sent = sent_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen at TDATA_WIDTH=32.
// Latency: n/a.
// Backpressure: tready driven always-on or in a 1,0,0 pattern.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stop, ifg_override;
    logic [15:0] frame_len, frame_count;
    logic [7:0]  ifg, seed;
    logic [3:0]  tid_in, tdest_in;
    logic        busy, done, config_err;
    logic [31:0] frames_sent;
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
    logic [7:0]  err_every;
    logic [31:0] frames_bad;
`endif

    int check_cnt = 0;
    int fail_cnt  = 0;

    AXIS_IF #(.TDATA_WIDTH(32), .TID_WIDTH(4), .TDEST_WIDTH(4), .TUSER_WIDTH(1)) axis_if_i ();

    axis_frame_gen dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .out_axis_if  (axis_if_i),
        .start        (start),
        .stop         (stop),
        .frame_len    (frame_len),
        .frame_count  (frame_count),
        .ifg          (ifg),
        .ifg_override (ifg_override),
        .seed         (seed),
        .tid_in       (tid_in),
        .tdest_in     (tdest_in),
        .busy         (busy),
        .done         (done),
        .config_err   (config_err),
        .frames_sent  (frames_sent)
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
        ,
        .err_every    (err_every),
        .frames_bad   (frames_bad)
`endif
    );

    always #5 clk = ~clk;

    // Expected beats of a 10-byte frame seeded 0x10.
    logic [31:0] f1_dat [3] = '{32'h13121110, 32'h17161514, 32'h00001918};
    logic [3:0]  f1_keep[3] = '{4'hF, 4'hF, 4'h3};
    logic        f1_last[3] = '{1'b0, 1'b0, 1'b1};

    // Handshake monitor, sampled on the falling edge.
    logic [31:0] mon_dat [$];
    logic [3:0]  mon_keep[$];
    logic        mon_last[$];
    int          mon_cyc [$];
    int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, cerr_cnt = 0, vld_cnt = 0, stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] p_dat;
    logic [3:0]  p_keep;
    logic        p_last;

    int rdy_mode = 0;
    int rdy_ph   = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (start === 1'b1) start_cyc = cyc;
        if (axis_if_i.tvalid === 1'b1 && axis_if_i.tready === 1'b1) begin
            mon_dat.push_back(axis_if_i.tdata);
            mon_keep.push_back(axis_if_i.tkeep);
            mon_last.push_back(axis_if_i.tlast);
            mon_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (config_err === 1'b1) cerr_cnt++;
        if (axis_if_i.tvalid === 1'b1) vld_cnt++;
        if (prev_stall) begin
            if (axis_if_i.tvalid !== 1'b1 || axis_if_i.tdata !== p_dat ||
                axis_if_i.tkeep !== p_keep || axis_if_i.tlast !== p_last)
                stall_viol++;
        end
        prev_stall = (axis_if_i.tvalid === 1'b1) && (axis_if_i.tready === 1'b0);
        p_dat  = axis_if_i.tdata;
        p_keep = axis_if_i.tkeep;
        p_last = axis_if_i.tlast;
    end

    // tready driver: always ready, or a repeating 1,0,0 pattern.
    initial begin
        axis_if_i.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) axis_if_i.tready = 1'b1;
            else begin
                axis_if_i.tready = (rdy_ph == 0);
                rdy_ph = (rdy_ph + 1) % 3;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon();
        mon_dat.delete(); mon_keep.delete(); mon_last.delete(); mon_cyc.delete();
        done_cnt = 0; cerr_cnt = 0; vld_cnt = 0; stall_viol = 0;
    endtask

    task automatic start_run(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] g,
                             input logic ovr, input logic [7:0] sd);
        frame_len = len; frame_count = cnt; ifg = g; ifg_override = ovr; seed = sd;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin step(1); n++; end
        ok = (done_cnt != 0);
        step(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        check_cnt++; if (axis_if_i.tvalid !== 1'b0) begin fail_cnt++; $display("FAIL reset_tvalid got=%b exp=0", axis_if_i.tvalid); end
        check_cnt++; if (axis_if_i.tlast !== 1'b0) begin fail_cnt++; $display("FAIL reset_tlast got=%b exp=0", axis_if_i.tlast); end
        check_cnt++; if (axis_if_i.tdata !== 32'h0 || axis_if_i.tkeep !== 4'h0 || axis_if_i.tstrb !== 4'h0)
            begin fail_cnt++; $display("FAIL reset_data got=%h/%h exp=0/0", axis_if_i.tdata, axis_if_i.tkeep); end
        check_cnt++; if (busy !== 1'b0 || done !== 1'b0 || config_err !== 1'b0)
            begin fail_cnt++; $display("FAIL reset_status got=%b%b%b exp=000", busy, done, config_err); end
        check_cnt++; if (frames_sent !== 32'd0) begin fail_cnt++; $display("FAIL reset_frames got=%0d exp=0", frames_sent); end
        check_cnt++; if (axis_if_i.tuser !== 1'b0 || axis_if_i.twakeup !== 1'b0)
            begin fail_cnt++; $display("FAIL reset_tuser got=%b/%b exp=0/0", axis_if_i.tuser, axis_if_i.twakeup); end
        reset_n = 1'b1;
        step(2);
        check_cnt++; if (busy !== 1'b0 || axis_if_i.tvalid !== 1'b0)
            begin fail_cnt++; $display("FAIL post_reset_idle got=%b/%b exp=0/0", busy, axis_if_i.tvalid); end
    endtask

    task automatic test_single_frame();
        bit ok;
        clear_mon();
        start_run(16'd10, 16'd1, 8'd0, 1'b0, 8'h10);
        check_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL single_busy got=%b exp=1", busy); end
        wait_done(50, ok);
        check_cnt++; if (!ok) begin fail_cnt++; $display("FAIL single_timeout got=no_done exp=done"); end
        check_cnt++; if (mon_dat.size() != 3) begin fail_cnt++; $display("FAIL single_beats got=%0d exp=3", mon_dat.size()); end
        for (int i = 0; i < 3 && i < mon_dat.size(); i++) begin
            check_cnt++;
            if (mon_dat[i] !== f1_dat[i] || mon_keep[i] !== f1_keep[i] || mon_last[i] !== f1_last[i]) begin
                fail_cnt++;
                $display("FAIL single_beat%0d got=%h/%h/%b exp=%h/%h/%b", i, mon_dat[i], mon_keep[i], mon_last[i], f1_dat[i], f1_keep[i], f1_last[i]);
            end
        end
        if (mon_dat.size() == 3) begin
            check_cnt++; if (mon_cyc[0] != start_cyc + 1) begin fail_cnt++; $display("FAIL single_latency got=%0d exp=%0d", mon_cyc[0], start_cyc + 1); end
            check_cnt++; if (done_cyc != mon_cyc[2] + 1) begin fail_cnt++; $display("FAIL single_done_cyc got=%0d exp=%0d", done_cyc, mon_cyc[2] + 1); end
        end
        check_cnt++; if (done_cnt != 1) begin fail_cnt++; $display("FAIL single_done_pulse got=%0d exp=1", done_cnt); end
        check_cnt++; if (frames_sent !== 32'd1 || busy !== 1'b0) begin fail_cnt++; $display("FAIL single_frames got=%0d/%b exp=1/0", frames_sent, busy); end
        check_cnt++; if (axis_if_i.tid !== 4'h5 || axis_if_i.tdest !== 4'hA) begin fail_cnt++; $display("FAIL single_route got=%h/%h exp=5/a", axis_if_i.tid, axis_if_i.tdest); end
    endtask

    task automatic test_ifg_frames();
        bit ok;
        clear_mon();
        start_run(16'd8, 16'd3, 8'd2, 1'b1, 8'h00);
        wait_done(80, ok);
        check_cnt++; if (!ok) begin fail_cnt++; $display("FAIL ifg_timeout got=no_done exp=done"); end
        check_cnt++; if (mon_dat.size() != 6 || vld_cnt != 6) begin fail_cnt++; $display("FAIL ifg_beats got=%0d/%0d exp=6/6", mon_dat.size(), vld_cnt); end
        for (int i = 0; i < 6 && i < mon_dat.size(); i++) begin
            check_cnt++;
            if (mon_dat[i] !== ((i % 2 == 0) ? 32'h03020100 : 32'h07060504) || mon_keep[i] !== 4'hF || mon_last[i] !== (i % 2 == 1)) begin
                fail_cnt++;
                $display("FAIL ifg_beat%0d got=%h/%h/%b", i, mon_dat[i], mon_keep[i], mon_last[i]);
            end
        end
        if (mon_dat.size() == 6) begin
            check_cnt++; if (mon_cyc[2] - mon_cyc[1] != 3 || mon_cyc[4] - mon_cyc[3] != 3)
                begin fail_cnt++; $display("FAIL ifg_gap got=%0d,%0d exp=3,3", mon_cyc[2] - mon_cyc[1], mon_cyc[4] - mon_cyc[3]); end
        end
        check_cnt++; if (frames_sent !== 32'd3) begin fail_cnt++; $display("FAIL ifg_frames got=%0d exp=3", frames_sent); end
    endtask

    task automatic test_stall();
        bit ok;
        rdy_mode = 1; rdy_ph = 0;
        step(1);
        clear_mon();
        start_run(16'd10, 16'd1, 8'd0, 1'b0, 8'h10);
        wait_done(80, ok);
        rdy_mode = 0;
        check_cnt++; if (!ok) begin fail_cnt++; $display("FAIL stall_timeout got=no_done exp=done"); end
        check_cnt++; if (mon_dat.size() != 3) begin fail_cnt++; $display("FAIL stall_beats got=%0d exp=3", mon_dat.size()); end
        for (int i = 0; i < 3 && i < mon_dat.size(); i++) begin
            check_cnt++;
            if (mon_dat[i] !== f1_dat[i] || mon_keep[i] !== f1_keep[i] || mon_last[i] !== f1_last[i]) begin
                fail_cnt++;
                $display("FAIL stall_beat%0d got=%h/%h/%b exp=%h/%h/%b", i, mon_dat[i], mon_keep[i], mon_last[i], f1_dat[i], f1_keep[i], f1_last[i]);
            end
        end
        check_cnt++; if (stall_viol != 0) begin fail_cnt++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
        check_cnt++; if (vld_cnt <= 3) begin fail_cnt++; $display("FAIL stall_occurred got=%0d exp=>3", vld_cnt); end
        check_cnt++; if (frames_sent !== 32'd1) begin fail_cnt++; $display("FAIL stall_frames got=%0d exp=1", frames_sent); end
    endtask

    task automatic test_stop_continuous();
        bit ok;
        int n = 0;
        clear_mon();
        // ifg input non-zero but override low: default gap of 0 applies.
        start_run(16'd4, 16'd0, 8'd5, 1'b0, 8'h20);
        while (mon_dat.size() < 4 && n < 100) begin step(1); n++; end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        wait_done(50, ok);
        step(5);
        check_cnt++; if (!ok) begin fail_cnt++; $display("FAIL stop_timeout got=no_done exp=done"); end
        check_cnt++; if (mon_dat.size() != 5) begin fail_cnt++; $display("FAIL stop_beats got=%0d exp=5", mon_dat.size()); end
        for (int i = 0; i < 5 && i < mon_dat.size(); i++) begin
            check_cnt++;
            if (mon_dat[i] !== 32'h23222120 || mon_keep[i] !== 4'hF || mon_last[i] !== 1'b1) begin
                fail_cnt++;
                $display("FAIL stop_beat%0d got=%h/%h/%b exp=23222120/f/1", i, mon_dat[i], mon_keep[i], mon_last[i]);
            end
        end
        if (mon_dat.size() == 5) begin
            check_cnt++; if (mon_cyc[4] - mon_cyc[0] != 4) begin fail_cnt++; $display("FAIL stop_b2b got=%0d exp=4", mon_cyc[4] - mon_cyc[0]); end
        end
        check_cnt++; if (frames_sent !== 32'd5 || done_cnt != 1) begin fail_cnt++; $display("FAIL stop_frames got=%0d/%0d exp=5/1", frames_sent, done_cnt); end
    endtask

    task automatic test_config_err();
        bit ok;
        clear_mon();
        start_run(16'd0, 16'd1, 8'd0, 1'b0, 8'h00);
        step(4);
        check_cnt++; if (cerr_cnt != 1) begin fail_cnt++; $display("FAIL cfgerr_pulse got=%0d exp=1", cerr_cnt); end
        check_cnt++; if (busy !== 1'b0 || vld_cnt != 0) begin fail_cnt++; $display("FAIL cfgerr_idle got=%b/%0d exp=0/0", busy, vld_cnt); end
        check_cnt++; if (frames_sent !== 32'd5) begin fail_cnt++; $display("FAIL cfgerr_frames_kept got=%0d exp=5", frames_sent); end
        // stop while idle must not shorten the next run
        stop = 1'b1; step(1); stop = 1'b0;
        clear_mon();
        start_run(16'd10, 16'd2, 8'd3, 1'b1, 8'h40);
        step(3);
        start_run(16'd0, 16'd1, 8'd0, 1'b0, 8'h99);
        wait_done(80, ok);
        check_cnt++; if (!ok) begin fail_cnt++; $display("FAIL busy_start_timeout got=no_done exp=done"); end
        check_cnt++; if (cerr_cnt != 0) begin fail_cnt++; $display("FAIL busy_start_cfgerr got=%0d exp=0", cerr_cnt); end
        check_cnt++; if (mon_dat.size() != 6 || frames_sent !== 32'd2) begin fail_cnt++; $display("FAIL busy_start_beats got=%0d/%0d exp=6/2", mon_dat.size(), frames_sent); end
        if (mon_dat.size() == 6) begin
            check_cnt++; if (mon_dat[3] !== 32'h43424140 || mon_dat[5] !== 32'h00004948 || mon_keep[5] !== 4'h3)
                begin fail_cnt++; $display("FAIL busy_start_data got=%h/%h/%h exp=43424140/00004948/3", mon_dat[3], mon_dat[5], mon_keep[5]); end
            check_cnt++; if (mon_cyc[3] - mon_cyc[2] != 4) begin fail_cnt++; $display("FAIL busy_start_gap got=%0d exp=4", mon_cyc[3] - mon_cyc[2]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n = 0;
        clear_mon();
        start_run(16'd10, 16'd1, 8'd0, 1'b0, 8'h10);
        while (mon_dat.size() < 1 && n < 20) begin step(1); n++; end
        check_cnt++; if (axis_if_i.tvalid !== 1'b1 || axis_if_i.tdata !== 32'h17161514)
            begin fail_cnt++; $display("FAIL midrst_beat2 got=%b/%h exp=1/17161514", axis_if_i.tvalid, axis_if_i.tdata); end
        reset_n = 1'b0;
        #1;
        check_cnt++; if (axis_if_i.tvalid !== 1'b0 || busy !== 1'b0 || axis_if_i.tdata !== 32'h0)
            begin fail_cnt++; $display("FAIL midrst_outputs got=%b/%b/%h exp=0/0/0", axis_if_i.tvalid, busy, axis_if_i.tdata); end
        step(2);
        reset_n = 1'b1;
        step(1);
        clear_mon();
        start_run(16'd10, 16'd1, 8'd0, 1'b0, 8'h10);
        wait_done(50, ok);
        check_cnt++; if (!ok || mon_dat.size() != 3) begin fail_cnt++; $display("FAIL midrst_restart got=%0d beats exp=3", mon_dat.size()); end
        for (int i = 0; i < 3 && i < mon_dat.size(); i++) begin
            check_cnt++;
            if (mon_dat[i] !== f1_dat[i] || mon_keep[i] !== f1_keep[i] || mon_last[i] !== f1_last[i]) begin
                fail_cnt++;
                $display("FAIL midrst_beat%0d got=%h/%h/%b exp=%h/%h/%b", i, mon_dat[i], mon_keep[i], mon_last[i], f1_dat[i], f1_keep[i], f1_last[i]);
            end
        end
        check_cnt++; if (frames_sent !== 32'd1) begin fail_cnt++; $display("FAIL midrst_frames got=%0d exp=1", frames_sent); end
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; frame_len = 16'd0; frame_count = 16'd1;
        ifg = 8'd0; ifg_override = 1'b0; seed = 8'd0; tid_in = 4'h5; tdest_in = 4'hA;
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
        err_every = 8'd0;
`endif
        reset_n = 1'b0;
        #2;
        test_reset();
        test_single_frame();
        test_ifg_frames();
        test_stall();
        test_stop_continuous();
        test_config_err();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
